// File: rtl/conv_operand_feeder_if.sv
// conv_operand_feeder_if: fmap/weight RAM read ports and MAC operand stream of the convolution feeder
// master: feeder side (drives reads and operands); slave: RAM/MAC side
interface conv_operand_feeder_if #(
  parameter int bitwidth = 17,
  parameter int fmap_aw  = 12,
  parameter int wt_aw    = 8
);
  logic                       fmap_rd_en;
  logic [fmap_aw-1:0]         fmap_addr;
  logic signed [bitwidth-1:0] fmap_data;
  logic                       wt_rd_en;
  logic [wt_aw-1:0]           wt_addr;
  logic signed [bitwidth-1:0] wt_data;
  logic signed [bitwidth-1:0] a;
  logic signed [bitwidth-1:0] b;
  logic                       op_valid;
  logic                       op_first;
  logic                       op_last;
  logic [7:0]                 out_row;
  logic [7:0]                 out_col;
  logic                       mac_reset;
  modport master (
    output fmap_rd_en, fmap_addr, wt_rd_en, wt_addr,
    input  fmap_data, wt_data,
    output a, b, op_valid, op_first, op_last, out_row, out_col, mac_reset
  );
  modport slave (
    input  fmap_rd_en, fmap_addr, wt_rd_en, wt_addr,
    output fmap_data, wt_data,
    input  a, b, op_valid, op_first, op_last, out_row, out_col, mac_reset
  );
endinterface

// File: rtl/conv_operand_feeder.sv
// conv_operand_feeder: streams (fmap, weight) operand pairs for every stride-1 output window to a free-running MAC
// Ports: clk; reset (async, active-low); start (pass request, sampled in IDLE); busy; done (1-cycle pulse);
//        bus (master): RAM read strobes/addresses, 1-cycle-latency RAM data, operands a/b with
//        op_valid/op_first/op_last/out_row/out_col, and mac_reset (active-low MAC reset)
module conv_operand_feeder #(
  parameter int in_height      = 32,
  parameter int in_width       = 32,
  parameter int kernal_height  = 5,
  parameter int kernal_width   = 5,
  parameter int kernal_channel = 3,
  parameter int bitwidth       = 17,
  parameter int fmap_aw        = 12,
  parameter int wt_aw          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  conv_operand_feeder_if.master bus
);
  localparam int oh = in_height - kernal_height + 1;
  localparam int ow = in_width - kernal_width + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, HOLD, DONE} state_t;
  state_t state;
  logic [7:0] row, col, ch, kr, kc, n_row, n_col, n_ch, n_kr, n_kc, row_s, col_s;
  logic kc_w, kr_w, ch_w, col_w, row_w, last_q, first_s, last_s, issue;
  // row/col/ch/kr/kc name the next pair to issue; last_q marks that the pair on the address bus is the final one
  always_comb begin
    kc_w  = kc == 8'(kernal_width - 1);
    kr_w  = kr == 8'(kernal_height - 1);
    ch_w  = ch == 8'(kernal_channel - 1);
    col_w = col == 8'(ow - 1);
    row_w = row == 8'(oh - 1);
    n_kc  = kc_w ? 8'd0 : kc + 8'd1;
    n_kr  = !kc_w ? kr : kr_w ? 8'd0 : kr + 8'd1;
    n_ch  = !(kc_w && kr_w) ? ch : ch_w ? 8'd0 : ch + 8'd1;
    n_col = !(kc_w && kr_w && ch_w) ? col : col_w ? 8'd0 : col + 8'd1;
    n_row = !(kc_w && kr_w && ch_w && col_w) ? row : row_w ? 8'd0 : row + 8'd1;
    issue = (state == IDLE && start) || (state == ISSUE && !last_q);
  end
  assign bus.a = bus.op_valid ? bus.fmap_data : '0;
  assign bus.b = bus.op_valid ? bus.wt_data : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      {row, col, ch, kr, kc, row_s, col_s} <= '0;
      {last_q, first_s, last_s, busy, done} <= '0;
      {bus.fmap_rd_en, bus.wt_rd_en, bus.op_valid, bus.op_first, bus.op_last, bus.mac_reset} <= '0;
      bus.fmap_addr <= '0;
      bus.wt_addr <= '0;
      bus.out_row <= '0;
      bus.out_col <= '0;
    end else begin
      case (state)
        IDLE:    state <= start ? ISSUE : IDLE;
        ISSUE:   state <= last_q ? DRAIN : ISSUE;
        DRAIN:   state <= HOLD;
        HOLD:    state <= DONE;
        default: state <= IDLE;
      endcase
      busy <= state == IDLE ? start : state == ISSUE || state == DRAIN;
      done <= state == HOLD;
      // MAC leaves reset with the first valid pair and re-enters it one cycle after the last
      bus.mac_reset <= state == ISSUE || state == DRAIN;
      bus.fmap_rd_en <= issue;
      bus.wt_rd_en <= issue;
      first_s <= issue && kc == 8'd0 && kr == 8'd0 && ch == 8'd0;
      last_s <= issue && kc_w && kr_w && ch_w;
      if (issue) begin
        bus.fmap_addr <= fmap_aw'(32'(ch) * 32'(in_height * in_width) + (32'(row) + 32'(kr)) * 32'(in_width)
                         + 32'(col) + 32'(kc));
        bus.wt_addr <= wt_aw'(32'(ch) * 32'(kernal_height * kernal_width) + 32'(kr) * 32'(kernal_width) + 32'(kc));
        row_s <= row;
        col_s <= col;
        last_q <= kc_w && kr_w && ch_w && col_w && row_w;
        {row, col, ch, kr, kc} <= {n_row, n_col, n_ch, n_kr, n_kc};
      end
      // second stage lines window tags up with the RAM data returned one cycle after the address
      bus.op_valid <= bus.fmap_rd_en;
      bus.op_first <= first_s;
      bus.op_last <= last_s;
      bus.out_row <= row_s;
      bus.out_col <= col_s;
    end
  end
endmodule

// File: tb/tb_conv_operand_feeder.sv
// tb_conv_operand_feeder: three feeder configurations checked cycle by cycle against an index-arithmetic model
module tb_conv_operand_feeder;
  logic clk = 0;
  logic reset = 1;
  logic [2:0] start = '0;
  int checks = 0;
  int errors = 0;
  int exp_a[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  always #5 clk = ~clk;
  // u[0]: 6x6 in, 3x3 kernel, 1 ch; u[1]: 6x6, 3x3, 2 ch; u[2]: 5x5, 5x5, 1 ch
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int IH = g == 2 ? 5 : 6;
    localparam int IW = IH;
    localparam int KH = g == 2 ? 5 : 3;
    localparam int KW = KH;
    localparam int CH = g == 1 ? 2 : 1;
    localparam int OW = IW - KW + 1;
    localparam int K = CH * KH * KW;
    localparam int N = (IH - KH + 1) * OW * K;
    logic busy, done;
    int c = 0;
    int vcnt = 0, run = 0, max_run = 0, first_cnt = 0, last_cnt = 0, done_cnt = 0;
    logic signed [16:0] a_log[$], b_log[$];
    int addr_log[$];
    conv_operand_feeder_if #(.bitwidth(17), .fmap_aw(12), .wt_aw(8)) bus ();
    conv_operand_feeder #(
      .in_height(IH), .in_width(IW), .kernal_height(KH), .kernal_width(KW), .kernal_channel(CH),
      .bitwidth(17), .fmap_aw(12), .wt_aw(8)
    ) dut (.clk(clk), .reset(reset), .start(start[g]), .busy(busy), .done(done), .bus(bus));
    function automatic logic signed [16:0] fval(int ad);
      return 17'(g == 2 ? ad - 12 : ad);
    endfunction
    function automatic logic signed [16:0] wval(int ad);
      return 17'(g == 0 ? 1 : g == 1 ? ad - 9 : ad % 3 - 1);
    endfunction
    function automatic int faddr(int q);
      int w = q / K;
      return (q / (KW * KH)) % CH * IH * IW + (w / OW + (q / KW) % KH) * IW + w % OW + q % KW;
    endfunction
    always @(posedge clk) begin
      if (bus.fmap_rd_en) bus.fmap_data <= fval(int'(bus.fmap_addr));
      if (bus.wt_rd_en) bus.wt_data <= wval(int'(bus.wt_addr));
    end
    // c counts cycles since the accepting edge: issue 1..N, valid 2..N+1, hold N+2, done N+3
    always @(posedge clk or negedge reset)
      if (!reset) c <= 0;
      else if (c == 0) c <= start[g] ? 1 : 0;
      else c <= c == N + 3 ? 0 : c + 1;
    always @(negedge clk) begin
      int q, p;
      logic re, ve;
      logic [7:0] ectl, gctl;
      logic signed [16:0] ae, be;
      q = c - 1;
      p = c - 2;
      re = c >= 1 && c <= N;
      ve = c >= 2 && c <= N + 1;
      ectl = {c >= 1 && c <= N + 2, c == N + 3, re, re, ve, ve && p % K == 0, ve && p % K == K - 1,
              c >= 2 && c <= N + 2};
      gctl = {busy, done, bus.fmap_rd_en, bus.wt_rd_en, bus.op_valid, bus.op_first, bus.op_last, bus.mac_reset};
      checks++;
      if (gctl !== ectl) begin
        errors++;
        $display("FAIL ctl inst%0d t=%0t got=%b exp=%b", g, $time, gctl, ectl);
      end
      ae = ve ? fval(faddr(p)) : 17'sd0;
      be = ve ? wval(p % K) : 17'sd0;
      checks++;
      if ({bus.a, bus.b} !== {ae, be}) begin
        errors++;
        $display("FAIL ab inst%0d t=%0t got=%0d,%0d exp=%0d,%0d", g, $time, bus.a, bus.b, ae, be);
      end
      if (re || !reset) begin
        checks++;
        if ({bus.fmap_addr, bus.wt_addr} !== (re ? {12'(faddr(q)), 8'(q % K)} : 20'd0)) begin
          errors++;
          $display("FAIL addr inst%0d t=%0t got=%0d,%0d exp=%0d,%0d", g, $time, bus.fmap_addr, bus.wt_addr,
                   re ? faddr(q) : 0, re ? q % K : 0);
        end
      end
      if (ve || !reset) begin
        checks++;
        if ({bus.out_row, bus.out_col} !== (ve ? {8'(p / K / OW), 8'(p / K % OW)} : 16'd0)) begin
          errors++;
          $display("FAIL pos inst%0d t=%0t got=%0d,%0d exp=%0d,%0d", g, $time, bus.out_row, bus.out_col,
                   ve ? p / K / OW : 0, ve ? p / K % OW : 0);
        end
      end
      if (bus.op_valid) begin
        run++;
        vcnt++;
        if (run > max_run) max_run = run;
        if (a_log.size() < K) begin
          a_log.push_back(bus.a);
          b_log.push_back(bus.b);
        end
      end else run = 0;
      if (bus.fmap_rd_en && addr_log.size() < 12) addr_log.push_back(int'(bus.fmap_addr));
      first_cnt += int'(bus.op_first);
      last_cnt += int'(bus.op_last);
      done_cnt += int'(done);
    end
  end
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic wait_done(int t0, int t1, int t2);
    int n = 0;
    while ((u[0].done_cnt < t0 || u[1].done_cnt < t1 || u[2].done_cnt < t2) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("wait_done", int'(n < 2000), 1);
  endtask
  initial begin
    int n, sum, d0, d1;
    #2 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", int'({u[0].busy, u[0].done, u[0].bus.fmap_rd_en, u[0].bus.op_valid, u[0].bus.mac_reset}), 0);
    reset = 1;
    @(negedge clk) start = 3'b111;
    @(negedge clk) start = 3'b000;
    repeat (3) @(negedge clk);
    start = 3'b011;
    @(negedge clk) start = 3'b000;
    repeat (44) @(negedge clk);
    start = 3'b011;
    @(negedge clk) start = 3'b000;
    wait_done(1, 1, 1);
    repeat (3) @(negedge clk);
    sum = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("win0_a%0d", i), int'(u[0].a_log[i]), exp_a[i]);
      sum += int'(u[0].a_log[i]) * int'(u[0].b_log[i]);
    end
    chk("mac_c_first", sum, 63);
    chk("run0", u[0].max_run, 144);
    chk("vcnt0", u[0].vcnt, 144);
    chk("last0", u[0].last_cnt, 16);
    chk("done0", u[0].done_cnt, 1);
    chk("ch2_addr", u[1].addr_log[9], 36);
    chk("b_first", int'(u[1].b_log[0]), -9);
    chk("b_last", int'(u[1].b_log[17]), 8);
    chk("last1", u[1].last_cnt, 16);
    chk("vcnt1", u[1].vcnt, 288);
    chk("done1", u[1].done_cnt, 1);
    chk("first2", u[2].first_cnt, 1);
    chk("last2", u[2].last_cnt, 1);
    chk("vcnt2", u[2].vcnt, 25);
    start[0] = 1;
    @(negedge clk) start[0] = 0;
    n = 0;
    while (!u[0].done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_p2", int'(n < 1000), 1);
    start[0] = 1;
    @(negedge clk);
    chk("gap_mac_reset", int'(u[0].bus.mac_reset), 0);
    chk("gap_busy", int'(u[0].busy), 0);
    @(negedge clk) start[0] = 0;
    chk("b2b_busy", int'(u[0].busy), 1);
    wait_done(3, 1, 1);
    repeat (3) @(negedge clk);
    chk("vcnt0_3", u[0].vcnt, 432);
    chk("run0_3", u[0].max_run, 144);
    start = 3'b111;
    @(negedge clk) start = 3'b000;
    n = 0;
    while (u[0].vcnt < 502 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("wait_p70", int'(n < 1000), 1);
    #2 reset = 0;
    #1;
    chk("arst_ctl0", int'({u[0].busy, u[0].done, u[0].bus.fmap_rd_en, u[0].bus.wt_rd_en, u[0].bus.op_valid,
                           u[0].bus.op_first, u[0].bus.op_last, u[0].bus.mac_reset}), 0);
    chk("arst_ab0", int'({u[0].bus.a, u[0].bus.b}), 0);
    chk("arst_addr0", int'({u[0].bus.fmap_addr, u[0].bus.wt_addr}), 0);
    chk("arst_pos1", int'({u[1].bus.out_row, u[1].bus.out_col, u[1].bus.op_valid, u[1].bus.mac_reset}), 0);
    d0 = u[0].done_cnt;
    d1 = u[1].done_cnt;
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("no_done0", u[0].done_cnt, d0);
    chk("no_done1", u[1].done_cnt, d1);
    chk("vcnt_abort", u[0].vcnt, 502);
    start = 3'b111;
    @(negedge clk) start = 3'b000;
    wait_done(4, 2, 3);
    repeat (3) @(negedge clk);
    chk("vcnt0_end", u[0].vcnt, 646);
    chk("run1_end", u[1].max_run, 288);
    chk("done2_end", u[2].done_cnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/conv_operand_feeder.md
Name: conv_operand_feeder

Overview:
- Operand-stream transmitter for the convolution MAC: walks every stride-1, no-padding output position of one feature map.
- For each position it reads fmap and weight buffers and streams kernal_channel*kernal_height*kernal_width signed (a, b) pairs, gapless, one pair per clock.
- The downstream MAC has no valid input and free-runs its own window counter. This block therefore owns the MAC's active-low reset so that the MAC's window boundaries line up with this block's op_first/op_last.

Parameters:
- in_height, 32, input feature-map rows.
- in_width, 32, input feature-map columns.
- kernal_height, 5, kernel rows.
- kernal_width, 5, kernel columns.
- kernal_channel, 3, input channels.
- bitwidth, 17, operand width (sign + 12 integer + 4 fraction).
- fmap_aw, 12, fmap address width.
- wt_aw, 8, weight address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a full pass (ignored unless IDLE)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of pass
- fmap_rd_en  out  1  fmap read strobe
- fmap_addr  out  fmap_aw  fmap read address
- fmap_data  in  bitwidth  signed fmap word; synchronous RAM, valid 1 cycle after fmap_rd_en
- wt_rd_en  out  1  weight read strobe
- wt_addr  out  wt_aw  weight read address
- wt_data  in  bitwidth  signed weight word; 1-cycle latency
- a  out  bitwidth  signed operand to MAC (fmap)
- b  out  bitwidth  signed operand to MAC (weight)
- op_valid  out  1  a/b carry a real pair
- op_first  out  1  first pair of a window
- op_last  out  1  last pair of a window
- out_row  out  8  output row of the current window, qualified by op_valid
- out_col  out  8  output column of the current window, qualified by op_valid
- mac_reset  out  1  active-low reset to the MAC; low except while streaming

Behaviour:
Derived values:
- OH = in_height-kernal_height+1, OW = in_width-kernal_width+1.
- K = kernal_channel*kernal_height*kernal_width; N = OH*OW*K.

Reset (reset=0, asynchronous):
- FSM goes to IDLE; all counters clear.
- busy, done, fmap_rd_en, wt_rd_en, op_valid, op_first, op_last and mac_reset are 0.
- a, b, addresses, out_row and out_col are 0.
- Reset mid-pass aborts the pass immediately, with no done pulse.

Loop order, outermost to innermost: out_row, out_col, ch, kr, kc.
- fmap_addr = ch*in_height*in_width + (out_row+kr)*in_width + (out_col+kc).
- wt_addr = ch*kernal_height*kernal_width + kr*kernal_width + kc.

FSM states:
- IDLE: start=1 at a clock edge moves to ISSUE; busy goes to 1.
- ISSUE: rd_en both 1; one address pair issued per cycle; N cycles total. After the Nth address, go to DRAIN.
- DRAIN: rd_en 0; the last data pair is presented this cycle. Go to HOLD.
- HOLD: op_valid 0; mac_reset stays 1 for this one cycle so the MAC's final accumulate edge and flag_over complete. Next state DONE.
- DONE: done=1 for one cycle; busy falls and mac_reset falls at the same edge. Next state IDLE.

Data path:
- op_valid is rd_en delayed 1 cycle, so op_valid is high for exactly N consecutive cycles with no bubbles.
- a = fmap_data and b = wt_data when op_valid=1, else 0. This is combinational from the RAM outputs.
- op_first/op_last/out_row/out_col are registered alongside the addresses and delayed 1 cycle to align with data.
- op_first=1 on pair index 0 of each window; op_last=1 on pair index K-1.

MAC alignment:
- mac_reset rises in the same cycle op_valid first rises.
- The MAC therefore starts counting at pair 0, and its flag_over coincides with the edge after each op_last.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle DONE returns to IDLE: ignored (only start sampled in IDLE counts).
- The ch/kr/kc counters wrap to 0 at their limits and carry into the next loop. The final carry out of out_row ends ISSUE.
- Address arithmetic is unsigned and uses full-width intermediates.
- Parameters must satisfy in_height*in_width*kernal_channel ≤ 2^fmap_aw.

Test Plan:
1. Params 6x6, kernel 3x3, channel 1; fmap[i]=i, wt=1; pulse start.
   - First window pairs: a = 0,1,2,6,7,8,12,13,14.
   - 16 windows; op_valid high 144 consecutive cycles.
   - Downstream MAC c=63 after first op_last; done one cycle after HOLD.
2. Same setup, channel 2, wt[j]=j-9 (signed).
   - Second-channel fmap_addr starts at 36.
   - op_last on every 18th pair; b values -9..8 repeat per window.
3. Pulse start again at cycles 5 and 50 of an active pass -> no effect; pair count still 144; single done.
4. Drop reset at pair 70 -> outputs all 0 within the same cycle; no done.
   - Release reset and pulse start -> stream restarts from window (0,0), pair 0.
5. Kernel equals input (5x5 in, 5x5 kernel) -> OH=OW=1; exactly K pairs with op_first and op_last each asserted once.
6. Back-to-back passes (start in cycle after done) -> second pass identical to first; mac_reset low at least one cycle between passes.
